sync_tx_arbiter: RTL and testbench

//  Source-domain scheduler that shares one Data_Sync CDC channel between NUM_REQ requesters.
//  - Round-robin arbitration between requesters.
//  - Launches one word per transfer with a single-cycle bus_enable.
//  - Holds unsync_bus stable through the receiver's synchronizer window.
//  - Enforces a gap before the next launch.

---
 rtl/sync_tx_arbiter.sv | 158 +++++++++++++++
 tb/tb_sync_tx_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sync_tx_arbiter
//  Description : Source-domain scheduler sharing one Data_Sync CDC channel
//                between NUM_REQ requesters. Round-robin pick, single-cycle
//                bus_enable launch, bus held stable through the receiver's
//                synchronizer window, then a quiet gap before the next pick.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_tx_arbiter #(
    parameter  int BUS_WIDTH   = 8,
    parameter  int NUM_REQ     = 4,
    parameter  int HOLD_CYCLES = 8,
    parameter  int GAP_CYCLES  = 2,
    localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [BUS_WIDTH-1:0]         unsync_bus,
    output logic                         bus_enable,
    output logic [ID_W-1:0]              src_id,
    output logic                         busy
);

    localparam int c_MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);

    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ID_W-1:0]    c_LAST_ID   = ID_W'(NUM_REQ - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_LAUNCH = 2'd1;
    localparam logic [1:0] c_S_HOLD   = 2'd2;
    localparam logic [1:0] c_S_GAP    = 2'd3;

    logic [1:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [ID_W-1:0]      r_ptr;
    logic [NUM_REQ-1:0]   r_grant;
    logic [BUS_WIDTH-1:0] r_bus;
    logic                 r_bus_en;
    logic [ID_W-1:0]      r_src_id;

    logic [1:0]           w_state_nxt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [BUS_WIDTH-1:0] w_bus_nxt;
    logic                 w_bus_en_nxt;
    logic [ID_W-1:0]      w_src_id_nxt;

    logic                 w_found;
    logic [ID_W-1:0]      w_win_idx;
    logic [ID_W-1:0]      w_scan_idx;
    logic [BUS_WIDTH-1:0] w_words [NUM_REQ];

    // Unpack the flat request data bus into one word per requester
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign w_words[g] = req_data[g*BUS_WIDTH +: BUS_WIDTH];
    end

    // Round-robin pick: first asserted request at or above r_ptr, wrapping
    always_comb begin
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_scan_idx = r_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[w_scan_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_scan_idx;
            end
            w_scan_idx = (w_scan_idx == c_LAST_ID) ? '0 : w_scan_idx + 1'b1;
        end
    end

    // Next-state and next-output logic; grant/bus_enable default to low
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ptr_nxt    = r_ptr;
        w_grant_nxt  = '0;
        w_bus_nxt    = r_bus;
        w_bus_en_nxt = 1'b0;
        w_src_id_nxt = r_src_id;
        case (r_state)
            c_S_IDLE: begin
                // req is only looked at here, so anything seen while busy is ignored
                if (w_found) begin
                    w_grant_nxt[w_win_idx] = 1'b1;
                    w_bus_en_nxt           = 1'b1;
                    w_bus_nxt              = w_words[w_win_idx];
                    w_src_id_nxt           = w_win_idx;
                    w_ptr_nxt              = (w_win_idx == c_LAST_ID) ? '0 : w_win_idx + 1'b1;
                    w_state_nxt            = c_S_LAUNCH;
                end
            end
            c_S_LAUNCH: begin
                w_cnt_nxt   = c_HOLD_LOAD;
                w_state_nxt = c_S_HOLD;
            end
            c_S_HOLD: begin
                if (r_cnt == '0) begin
                    if (GAP_CYCLES > 0) begin
                        w_cnt_nxt   = c_GAP_LOAD;
                        w_state_nxt = c_S_GAP;
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            c_S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer in flight
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= c_S_IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_grant  <= '0;
            r_bus    <= '0;
            r_bus_en <= 1'b0;
            r_src_id <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ptr    <= w_ptr_nxt;
            r_grant  <= w_grant_nxt;
            r_bus    <= w_bus_nxt;
            r_bus_en <= w_bus_en_nxt;
            r_src_id <= w_src_id_nxt;
        end
    end

    assign grant      = r_grant;
    assign unsync_bus = r_bus;
    assign bus_enable = r_bus_en;
    assign src_id     = r_src_id;
    assign busy       = (r_state != c_S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sync_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_tx_arbiter
//  Description : Directed self-checking bench for sync_tx_arbiter, with a
//                small Data_Sync receiver model on the same clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_tx_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic [7:0]  unsync_bus;
    logic        bus_enable;
    logic [1:0]  src_id;
    logic        busy;

    int n_checks;
    int n_fail;

    sync_tx_arbiter #(
        .BUS_WIDTH   (8),
        .NUM_REQ     (4),
        .HOLD_CYCLES (8),
        .GAP_CYCLES  (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable),
        .src_id     (src_id),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Receiver model: 2-flop enable synchronizer, edge detect, capture bus
    logic [2:0] ds_ff;
    logic       ds_pulse;
    logic [7:0] ds_bus;
    always @(posedge CLK) begin
        if (RST) begin
            ds_ff    <= 3'b000;
            ds_pulse <= 1'b0;
            ds_bus   <= 8'h00;
        end else begin
            ds_ff    <= {ds_ff[1:0], bus_enable};
            ds_pulse <= ds_ff[1] & ~ds_ff[2];
            if (ds_ff[1] & ~ds_ff[2]) ds_bus <= unsync_bus;
        end
    end

    task automatic wait_launch(input int budget, output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge CLK);
            cycles++;
            if (bus_enable === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge CLK);
            if (busy === 1'b0) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        RST      = 1'b1;
        req      = 4'hF;
        req_data = 32'hDEADBEEF;
        repeat (2) @(negedge CLK);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        n_checks++; if (bus_enable !== 1'b0) begin n_fail++; $display("FAIL reset_bus_enable got=%b exp=0", bus_enable); end
        n_checks++; if (unsync_bus !== 8'h00) begin n_fail++; $display("FAIL reset_unsync_bus got=%h exp=00", unsync_bus); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (src_id !== 2'd0) begin n_fail++; $display("FAIL reset_src_id got=%0d exp=0", src_id); end
        RST = 1'b0;
        req = 4'h0;
    endtask

    task automatic test_single_launch;
        bit seen;
        int cyc;
        int bad_en, bad_bus, bad_busy;
        req_data = 32'h0000A200;
        req      = 4'b0010;
        wait_launch(4, seen, cyc);
        n_checks++; if (!seen || cyc !== 1) begin n_fail++; $display("FAIL single_latency got=%0d exp=1", cyc); end
        n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL single_grant got=%b exp=0010", grant); end
        n_checks++; if (unsync_bus !== 8'hA2) begin n_fail++; $display("FAIL single_bus got=%h exp=a2", unsync_bus); end
        n_checks++; if (src_id !== 2'd1) begin n_fail++; $display("FAIL single_src_id got=%0d exp=1", src_id); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_launch got=%b exp=1", busy); end
        req     = 4'b0000;
        bad_en  = 0;
        bad_bus = 0;
        bad_busy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (bus_enable !== 1'b0 || grant !== 4'b0000) bad_en++;
            if (unsync_bus !== 8'hA2) bad_bus++;
            if (busy !== 1'b1) bad_busy++;
        end
        n_checks++; if (bad_en !== 0) begin n_fail++; $display("FAIL single_pulse_width got=%0d extra cycles exp=0", bad_en); end
        n_checks++; if (bad_bus !== 0) begin n_fail++; $display("FAIL single_bus_hold got=%0d unstable cycles exp=0", bad_bus); end
        n_checks++; if (bad_busy !== 0) begin n_fail++; $display("FAIL single_busy_window got=%0d low cycles exp=0", bad_busy); end
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got=%b exp=0", busy); end
        n_checks++; if (unsync_bus !== 8'hA2) begin n_fail++; $display("FAIL single_bus_idle got=%h exp=a2", unsync_bus); end
    endtask

    task automatic test_round_robin;
        bit         seen;
        int         cyc;
        logic [3:0] exp_g;
        logic [7:0] exp_w;
        logic [1:0] exp_id;
        RST = 1'b1;
        @(negedge CLK);
        RST      = 1'b0;
        req_data = 32'h44332211;
        req      = 4'hF;
        for (int n = 0; n < 5; n++) begin
            exp_id = 2'(n % 4);
            exp_g  = 4'b0001 << exp_id;
            exp_w  = 8'h11 * (8'(exp_id) + 8'd1);
            wait_launch(20, seen, cyc);
            n_checks++; if (!seen) begin n_fail++; $display("FAIL rr_timeout launch=%0d got=none exp=pulse", n); end
            n_checks++; if (cyc !== ((n == 0) ? 1 : 12)) begin n_fail++; $display("FAIL rr_spacing launch=%0d got=%0d exp=%0d", n, cyc, (n == 0) ? 1 : 12); end
            n_checks++; if (grant !== exp_g) begin n_fail++; $display("FAIL rr_grant launch=%0d got=%b exp=%b", n, grant, exp_g); end
            n_checks++; if (src_id !== exp_id) begin n_fail++; $display("FAIL rr_src_id launch=%0d got=%0d exp=%0d", n, src_id, exp_id); end
            n_checks++; if (unsync_bus !== exp_w) begin n_fail++; $display("FAIL rr_bus launch=%0d got=%h exp=%h", n, unsync_bus, exp_w); end
        end
        req = 4'h0;
        wait_idle(20, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rr_idle_timeout got=busy exp=idle"); end
    endtask

    task automatic test_skip_idle_requesters;
        bit seen;
        int cyc;
        // pointer sits at 1 here: requester 2 is the first asserted
        req = 4'b0100;
        wait_launch(4, seen, cyc);
        n_checks++; if (!seen || grant !== 4'b0100) begin n_fail++; $display("FAIL skip_first got=%b exp=0100", grant); end
        req = 4'b1001;
        wait_launch(20, seen, cyc);
        n_checks++; if (!seen || cyc !== 12) begin n_fail++; $display("FAIL skip_spacing got=%0d exp=12", cyc); end
        n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL skip_grant3 got=%b exp=1000", grant); end
        n_checks++; if (src_id !== 2'd3) begin n_fail++; $display("FAIL skip_src3 got=%0d exp=3", src_id); end
        req = 4'b0001;
        wait_launch(20, seen, cyc);
        n_checks++; if (!seen || grant !== 4'b0001) begin n_fail++; $display("FAIL skip_grant0 got=%b exp=0001", grant); end
        req = 4'b0000;
        wait_idle(20, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL skip_idle_timeout got=busy exp=idle"); end
    endtask

    task automatic test_reset_mid_transfer;
        bit seen;
        int cyc;
        // pointer is 1: grant goes to 2 and the pointer moves to 3
        req_data = 32'h005A0000;
        req      = 4'b0100;
        wait_launch(4, seen, cyc);
        n_checks++; if (!seen || grant !== 4'b0100) begin n_fail++; $display("FAIL rmid_launch got=%b exp=0100", grant); end
        req = 4'b0000;
        repeat (3) @(negedge CLK);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_in_hold got=%b exp=1", busy); end
        RST = 1'b1;
        @(negedge CLK);
        n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rmid_grant got=%b exp=0000", grant); end
        n_checks++; if (bus_enable !== 1'b0) begin n_fail++; $display("FAIL rmid_bus_enable got=%b exp=0", bus_enable); end
        n_checks++; if (unsync_bus !== 8'h00) begin n_fail++; $display("FAIL rmid_bus got=%h exp=00", unsync_bus); end
        n_checks++; if (src_id !== 2'd0) begin n_fail++; $display("FAIL rmid_src_id got=%0d exp=0", src_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        RST = 1'b0;
        @(negedge CLK);
        n_checks++; if (bus_enable !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL rmid_replay got=%b exp=0000", grant); end
        // pointer back at 0 picks 2; a stale pointer of 3 would pick 3
        req = 4'b1100;
        wait_launch(4, seen, cyc);
        n_checks++; if (!seen || cyc !== 1) begin n_fail++; $display("FAIL rmid_latency got=%0d exp=1", cyc); end
        n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL rmid_ptr_grant got=%b exp=0100", grant); end
        n_checks++; if (src_id !== 2'd2) begin n_fail++; $display("FAIL rmid_ptr_src got=%0d exp=2", src_id); end
        req = 4'b0000;
        wait_idle(20, seen);
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rmid_idle_timeout got=busy exp=idle"); end
    endtask

    task automatic test_hold_ignore;
        bit seen;
        int cyc;
        int pulses, bad_bus, idle_left;
        req_data = 32'h00000055;
        req      = 4'b0001;
        wait_launch(4, seen, cyc);
        n_checks++; if (!seen || grant !== 4'b0001) begin n_fail++; $display("FAIL hold_launch got=%b exp=0001", grant); end
        req     = 4'b0000;
        pulses  = 0;
        bad_bus = 0;
        idle_left = 5;
        for (int k = 0; k < 30 && idle_left > 0; k++) begin
            if (k == 2) begin
                req      = 4'b0010;
                req_data = 32'h000077FF;
            end
            if (k == 4) req = 4'b0000;
            @(negedge CLK);
            if (bus_enable === 1'b1 || grant !== 4'b0000) pulses++;
            if (unsync_bus !== 8'h55) bad_bus++;
            if (busy === 1'b0) idle_left--;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL hold_req_ignored got=%0d grants exp=0", pulses); end
        n_checks++; if (bad_bus !== 0) begin n_fail++; $display("FAIL hold_data_frozen got=%0d changes exp=0", bad_bus); end
        n_checks++; if (idle_left !== 0) begin n_fail++; $display("FAIL hold_idle_timeout got=%0d exp=0", idle_left); end
    endtask

    task automatic test_data_sync;
        bit         seen;
        int         cyc;
        logic [7:0] w;
        for (int n = 0; n < 3; n++) begin
            w        = (n == 0) ? 8'hA2 : (n == 1) ? 8'h55 : 8'hBC;
            req_data = {16'h0000, w, 8'h00};
            req      = 4'b0010;
            wait_launch(4, seen, cyc);
            req  = 4'b0000;
            seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge CLK);
                if (ds_pulse === 1'b1) seen = 1'b1;
            end
            n_checks++; if (!seen) begin n_fail++; $display("FAIL ds_pulse_timeout word=%h got=none exp=pulse", w); end
            n_checks++; if (ds_bus !== w) begin n_fail++; $display("FAIL ds_sync_bus got=%h exp=%h", ds_bus, w); end
            wait_idle(20, seen);
            n_checks++; if (!seen) begin n_fail++; $display("FAIL ds_idle_timeout got=busy exp=idle"); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        RST      = 1'b1;
        req      = 4'h0;
        req_data = 32'h0;
        @(negedge CLK);
        test_reset();
        test_single_launch();
        test_round_robin();
        test_skip_idle_requesters();
        test_reset_mid_transfer();
        test_hold_ignore();
        test_data_sync();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
